// File: rtl/pcie_phy_pkg.sv
// Shared PHY logical-layer constants and types for the TS1/TS2 ordered-set receive path.
package pcie_phy_pkg;

    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] PAD        = 8'hF7;
    localparam logic [7:0] TS1_ID     = 8'h4A;
    localparam logic [7:0] TS2_ID     = 8'h45;
    localparam logic [7:0] TS1_INV_ID = 8'hB5;
    localparam logic [7:0] TS2_INV_ID = 8'hBA;

    typedef struct packed {
        logic [2:0] reserved;
        logic       compliance_rx;
        logic       scramble_dis;
        logic       loopback;
        logic       link_dis;
        logic       hot_reset;
    } training_ctrl_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_B1,
        ST_B2,
        ST_B3
    } os_rx_st_e;

    // Link and lane number symbols are either plain data or the PAD control symbol.
    function automatic logic link_lane_sym_ok(input logic [7:0] sym, input logic is_k);
        return !is_k || (sym == PAD);
    endfunction

endpackage

// File: rtl/ltssm_os_decoder_if.sv
// Per-lane AXIS symbol stream feeding the ordered-set decoder, all lanes packed side by side.
interface ltssm_os_decoder_if #(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8
);
    logic [MAX_NUM_LANES*DATA_WIDTH-1:0] tdata;
    logic [MAX_NUM_LANES*KEEP_WIDTH-1:0] tkeep;
    logic [MAX_NUM_LANES*KEEP_WIDTH-1:0] tuser;
    logic [MAX_NUM_LANES-1:0]            tvalid;
    logic [MAX_NUM_LANES-1:0]            tlast;
    logic [MAX_NUM_LANES-1:0]            tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/ltssm_os_decoder_lane.sv
// Single-lane TS1/TS2 parser: 4-beat FSM with shadow registers committed only on a clean set.
// LTSSM_OS_POLARITY_DET_EN accepts inverted identifiers and flags lane polarity inversion.
module ts_lane_decoder
    import pcie_phy_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [31:0]    tdata,
    input  logic [3:0]     tkeep,
    input  logic [3:0]     tuser,
    input  logic           tvalid,
    input  logic           tlast,
    output logic           ts1_valid,
    output logic           ts2_valid,
    output logic           os_error,
    output logic           polarity_inv,
    output logic [7:0]     link_num,
    output logic [7:0]     lane_num,
    output logic [7:0]     n_fts,
    output logic [7:0]     rate_id,
    output training_ctrl_t training_ctrl
);

    os_rx_st_e      state_q, state_d;
    logic [7:0]     link_sh, lane_sh, nfts_sh, rate_sh, id_q;
    training_ctrl_t ctrl_sh;
    logic           keep_full, com_sym0, beat0_ok, id_ok, id_run_ok, b1_ok, b2_ok, b3_ok;
    logic           err_c, done_c, load_b0_c, load_b1_c;

    assign keep_full = (tkeep == 4'hF);
    assign com_sym0  = (tdata[7:0] == COM) && tuser[0];
    assign beat0_ok  = keep_full && !tlast &&
                       link_lane_sym_ok(tdata[15:8], tuser[1]) &&
                       link_lane_sym_ok(tdata[23:16], tuser[2]);

`ifdef LTSSM_OS_POLARITY_DET_EN
    assign id_ok = tdata[23:16] inside {TS1_ID, TS2_ID, TS1_INV_ID, TS2_INV_ID};
`else
    assign id_ok = tdata[23:16] inside {TS1_ID, TS2_ID};
`endif

    // Symbol 6 fixes the set type; every later identifier symbol must repeat it.
    assign b1_ok     = keep_full && !tlast && (tuser[3:1] == 3'b000) && id_ok &&
                       (tdata[31:24] == tdata[23:16]);
    assign id_run_ok = (tuser == 4'h0) && (tdata == {4{id_q}});
    assign b2_ok     = keep_full && !tlast && id_run_ok;
    assign b3_ok     = keep_full && tlast && id_run_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    // A COM in symbol 0 always restarts framing, whatever beat we thought we were on.
    always_comb begin
        state_d = state_q;
        if (tvalid) begin
            if (com_sym0) begin
                state_d = beat0_ok ? ST_B1 : ST_HUNT;
            end else begin
                case (state_q)
                    ST_B1:   state_d = b1_ok ? ST_B2 : ST_HUNT;
                    ST_B2:   state_d = b2_ok ? ST_B3 : ST_HUNT;
                    ST_B3:   state_d = ST_HUNT;
                    default: state_d = ST_HUNT;
                endcase
            end
        end
    end

    always_comb begin
        err_c     = 1'b0;
        done_c    = 1'b0;
        load_b0_c = 1'b0;
        load_b1_c = 1'b0;
        if (tvalid) begin
            if (com_sym0) begin
                load_b0_c = beat0_ok;
                err_c     = (state_q != ST_HUNT) || !beat0_ok;
            end else begin
                case (state_q)
                    ST_B1: begin
                        load_b1_c = b1_ok;
                        err_c     = !b1_ok;
                    end
                    ST_B2:   err_c = !b2_ok;
                    ST_B3: begin
                        done_c = b3_ok;
                        err_c  = !b3_ok;
                    end
                    default: err_c = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts1_valid     <= 1'b0;
            ts2_valid     <= 1'b0;
            os_error      <= 1'b0;
            link_sh       <= '0;
            lane_sh       <= '0;
            nfts_sh       <= '0;
            rate_sh       <= '0;
            ctrl_sh       <= '0;
            id_q          <= '0;
            link_num      <= '0;
            lane_num      <= '0;
            n_fts         <= '0;
            rate_id       <= '0;
            training_ctrl <= '0;
        end else begin
            ts1_valid <= done_c && ((id_q == TS1_ID) || (id_q == TS1_INV_ID));
            ts2_valid <= done_c && ((id_q == TS2_ID) || (id_q == TS2_INV_ID));
            os_error  <= err_c;
            if (load_b0_c) begin
                link_sh <= tdata[15:8];
                lane_sh <= tdata[23:16];
                nfts_sh <= tdata[31:24];
            end
            if (load_b1_c) begin
                rate_sh <= tdata[7:0];
                ctrl_sh <= training_ctrl_t'(tdata[15:8]);
                id_q    <= tdata[23:16];
            end
            if (done_c) begin
                link_num      <= link_sh;
                lane_num      <= lane_sh;
                n_fts         <= nfts_sh;
                rate_id       <= rate_sh;
                training_ctrl <= ctrl_sh;
            end
        end
    end

`ifdef LTSSM_OS_POLARITY_DET_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            polarity_inv <= 1'b0;
        else if (done_c && ((id_q == TS1_INV_ID) || (id_q == TS2_INV_ID)))
            polarity_inv <= 1'b1;
    end
`else
    assign polarity_inv = 1'b0;
`endif

endmodule

// File: rtl/ltssm_os_decoder.sv
// Multi-lane TS1/TS2 receive decoder: one independent ts_lane_decoder per lane.
// Optional macro LTSSM_OS_POLARITY_DET_EN enables inverted-identifier polarity detection.
module ltssm_os_decoder
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    ltssm_os_decoder_if.slave                  s_axis,
    output logic [MAX_NUM_LANES-1:0]           ts1_valid_o,
    output logic [MAX_NUM_LANES-1:0]           ts2_valid_o,
    output logic [MAX_NUM_LANES-1:0][7:0]      link_num_o,
    output logic [MAX_NUM_LANES-1:0][7:0]      lane_num_o,
    output logic [MAX_NUM_LANES-1:0][7:0]      n_fts_o,
    output logic [MAX_NUM_LANES-1:0][7:0]      rate_id_o,
    output training_ctrl_t [MAX_NUM_LANES-1:0] training_ctrl_o,
    output logic [MAX_NUM_LANES-1:0]           os_error_o,
    output logic [MAX_NUM_LANES-1:0]           polarity_inv_o
);

    assign s_axis.tready = '1;

    for (genvar i = 0; i < MAX_NUM_LANES; i++) begin : g_lane
        ts_lane_decoder u_lane (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .tdata         (s_axis.tdata[DATA_WIDTH*i +: DATA_WIDTH]),
            .tkeep         (s_axis.tkeep[KEEP_WIDTH*i +: KEEP_WIDTH]),
            .tuser         (s_axis.tuser[KEEP_WIDTH*i +: KEEP_WIDTH]),
            .tvalid        (s_axis.tvalid[i]),
            .tlast         (s_axis.tlast[i]),
            .ts1_valid     (ts1_valid_o[i]),
            .ts2_valid     (ts2_valid_o[i]),
            .os_error      (os_error_o[i]),
            .polarity_inv  (polarity_inv_o[i]),
            .link_num      (link_num_o[i]),
            .lane_num      (lane_num_o[i]),
            .n_fts         (n_fts_o[i]),
            .rate_id       (rate_id_o[i]),
            .training_ctrl (training_ctrl_o[i])
        );
    end

endmodule
